// File: rtl/spi_exe_pkg.sv
// Shared types and frame constants for the SPI execution-unit host driver.
package spi_exe_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SELECT   = 3'd1,
    SEND     = 3'd2,
    GAP_WAIT = 3'd3,
    RECV     = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam int M_DEF   = 8;
  localparam int N_DEF   = 4;
  localparam int F_DEF   = 4;
  localparam int GAP_DEF = 2;

  localparam int TX_BITS = 2 * M_DEF + N_DEF;
  localparam int RX_BITS = M_DEF + F_DEF;

  function automatic int frame_tx_bits(input int m, input int n);
    return 2 * m + n;
  endfunction

  function automatic int frame_rx_bits(input int m, input int f);
    return m + f;
  endfunction

endpackage

// File: rtl/spi_exe_host_shreg.sv
// Shift register with parallel load and MSB-first serial in/out.
module spi_exe_host_shreg #(
  parameter int W = 8
) (
  input  logic         i_sclk,
  input  logic         i_rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift_en,
  input  logic         ser_in,
  output logic [W-1:0] par_out,
  output logic         ser_out
);

  logic [W-1:0] data_reg;

  always_ff @(posedge i_sclk or negedge i_rst) begin
    if (!i_rst) begin
      data_reg <= '0;
    end else if (load) begin
      data_reg <= load_data;
    end else if (shift_en) begin
      data_reg <= {data_reg[W-2:0], ser_in};
    end
  end

  assign par_out = data_reg;
  assign ser_out = data_reg[W-1];

endmodule

// File: rtl/spi_exe_host.sv
// Host-side SPI frame driver for the SPI execution unit slave.
// Optional sticky start-while-busy error flag: define SPI_EXE_HOST_ERR_EN.
module spi_exe_host
  import spi_exe_pkg::*;
#(
  parameter int M   = M_DEF,
  parameter int N   = N_DEF,
  parameter int F   = F_DEF,
  parameter int GAP = GAP_DEF
) (
  input  logic         i_sclk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [M-1:0] i_arg_a,
  input  logic [M-1:0] i_arg_b,
  input  logic [N-1:0] i_oper,
  output logic         o_busy,
  output logic         o_done,
  output logic [M-1:0] o_result,
  output logic [F-1:0] o_flags,
  output logic         o_cs_n,
  output logic         o_mosi,
  input  logic         i_miso,
  output logic         o_err,
  input  logic         i_err_clr
);

  localparam int TX_W  = frame_tx_bits(M, N);
  localparam int RX_W  = frame_rx_bits(M, F);
  localparam int CNT_W = $clog2(TX_W + 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [3:0]       gap_cnt_reg, gap_cnt_next;
  logic             cs_n_reg, mosi_reg, busy_reg, done_reg;
  logic [M-1:0]     result_reg;
  logic [F-1:0]     flags_reg;

  logic             tx_load, tx_shift, tx_ser;
  logic [TX_W-1:0]  tx_par_unused;
  logic             rx_shift, rx_ser_unused, rx_msb_unused;
  logic [RX_W-1:0]  rx_par, rx_next;
  logic             rx_last;

  // TX: loaded on accept, shifted on every edge that lands in SEND so the
  // MOSI flop always holds the bit currently on the wire.
  spi_exe_host_shreg #(.W(TX_W)) u_tx (
    .i_sclk    (i_sclk),
    .i_rst     (i_rst),
    .load      (tx_load),
    .load_data ({i_arg_a, i_arg_b, i_oper}),
    .shift_en  (tx_shift),
    .ser_in    (1'b0),
    .par_out   (tx_par_unused),
    .ser_out   (tx_ser)
  );

  spi_exe_host_shreg #(.W(RX_W)) u_rx (
    .i_sclk    (i_sclk),
    .i_rst     (i_rst),
    .load      (1'b0),
    .load_data ('0),
    .shift_en  (rx_shift),
    .ser_in    (i_miso),
    .par_out   (rx_par),
    .ser_out   (rx_ser_unused)
  );

  assign tx_load       = (state_reg == IDLE) && i_start;
  assign tx_shift      = (state_next == SEND);
  assign rx_shift      = (state_reg == RECV);
  assign rx_next       = {rx_par[RX_W-2:0], i_miso};
  assign rx_msb_unused = rx_par[RX_W-1];
  assign rx_last       = (state_reg == RECV) && (bit_cnt_reg == CNT_W'(RX_W - 1));

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    gap_cnt_next = gap_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (i_start) state_next = SELECT;
      end
      SELECT: state_next = SEND;
      SEND: begin
        if (bit_cnt_reg == CNT_W'(TX_W - 1)) begin
          state_next   = GAP_WAIT;
          bit_cnt_next = '0;
        end else begin
          bit_cnt_next = bit_cnt_reg + 1'b1;
        end
      end
      GAP_WAIT: begin
        if (gap_cnt_reg == 4'(GAP - 1)) begin
          state_next   = RECV;
          gap_cnt_next = '0;
        end else begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end
      RECV: begin
        if (rx_last) begin
          state_next   = DONE;
          bit_cnt_next = '0;
        end else begin
          bit_cnt_next = bit_cnt_reg + 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are computed from the next state so they are registered yet
  // line up with the state they describe.
  always_ff @(posedge i_sclk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      gap_cnt_reg <= '0;
      cs_n_reg    <= 1'b1;
      mosi_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      result_reg  <= '0;
      flags_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      gap_cnt_reg <= gap_cnt_next;
      cs_n_reg    <= !((state_next == SELECT) || (state_next == SEND) ||
                       (state_next == GAP_WAIT) || (state_next == RECV));
      mosi_reg    <= (state_next == SEND) ? tx_ser : 1'b0;
      busy_reg    <= (state_next != IDLE);
      done_reg    <= (state_next == DONE);
      if (rx_last) begin
        result_reg <= rx_next[RX_W-1 -: M];
        flags_reg  <= rx_next[F-1:0];
      end
    end
  end

  assign o_cs_n   = cs_n_reg;
  assign o_mosi   = mosi_reg;
  assign o_busy   = busy_reg;
  assign o_done   = done_reg;
  assign o_result = result_reg;
  assign o_flags  = flags_reg;

`ifdef SPI_EXE_HOST_ERR_EN
  logic err_reg;

  // Set has priority over clear when both happen in the same cycle.
  always_ff @(posedge i_sclk or negedge i_rst) begin
    if (!i_rst) begin
      err_reg <= 1'b0;
    end else if (i_start && busy_reg) begin
      err_reg <= 1'b1;
    end else if (i_err_clr) begin
      err_reg <= 1'b0;
    end
  end

  assign o_err = err_reg;
`else
  logic err_clr_unused;

  assign err_clr_unused = i_err_clr;
  assign o_err          = 1'b0;
`endif

endmodule

// File: tb/tb_spi_exe_host.sv
// Directed bench for spi_exe_host: vector table plus back-to-back, error and reset sequences.
module tb_spi_exe_host;

  logic       i_sclk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_start = 1'b0;
  logic       start5 = 1'b0;
  logic [7:0] i_arg_a = '0;
  logic [7:0] i_arg_b = '0;
  logic [3:0] i_oper = '0;
  logic       i_miso = 1'b0;
  logic       miso5 = 1'b0;
  logic       i_err_clr = 1'b0;

  logic       o_busy, o_done, o_cs_n, o_mosi, o_err;
  logic [7:0] o_result;
  logic [3:0] o_flags;
  logic       busy5, done5, cs_n5, mosi5, err5;
  logic [7:0] result5;
  logic [3:0] flags5;

  int checks = 0;
  int errors = 0;

  always #5 i_sclk = ~i_sclk;

  spi_exe_host dut (
    .i_sclk(i_sclk), .i_rst(i_rst), .i_start(i_start),
    .i_arg_a(i_arg_a), .i_arg_b(i_arg_b), .i_oper(i_oper),
    .o_busy(o_busy), .o_done(o_done), .o_result(o_result), .o_flags(o_flags),
    .o_cs_n(o_cs_n), .o_mosi(o_mosi), .i_miso(i_miso),
    .o_err(o_err), .i_err_clr(i_err_clr)
  );

  spi_exe_host #(.GAP(5)) dut5 (
    .i_sclk(i_sclk), .i_rst(i_rst), .i_start(start5),
    .i_arg_a(i_arg_a), .i_arg_b(i_arg_b), .i_oper(i_oper),
    .o_busy(busy5), .o_done(done5), .o_result(result5), .o_flags(flags5),
    .o_cs_n(cs_n5), .o_mosi(mosi5), .i_miso(miso5),
    .o_err(err5), .i_err_clr(i_err_clr)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  op;
    logic [7:0]  rres;
    logic [3:0]  rflg;
    logic [19:0] exp_mosi;
  } vec_t;

  vec_t vecs [4];

`ifdef SPI_EXE_HOST_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One transaction; cycle k is the k-th clock period after the accepting edge.
  task automatic run_txn(input vec_t v, input bit keep, input int pulse_at, input bit with5);
    logic [19:0] mosi_cap;
    logic [11:0] resp;
    int          done_cyc, done_cnt, done5_cyc, last;
    bit          cs_ok, busy_ok;
    mosi_cap  = '0;
    resp      = {v.rres, v.rflg};
    done_cyc  = -1;
    done_cnt  = 0;
    done5_cyc = -1;
    cs_ok     = 1'b1;
    busy_ok   = 1'b1;
    last      = with5 ? 40 : 37;
    i_arg_a   = v.a;
    i_arg_b   = v.b;
    i_oper    = v.op;
    i_start   = 1'b1;
    start5    = with5;
    @(posedge i_sclk);
    #1;
    if (!keep) i_start = 1'b0;
    start5 = 1'b0;
    for (int k = 1; k <= last; k++) begin
      @(negedge i_sclk);
      if (k >= 2 && k <= 21) mosi_cap[21-k] = o_mosi;
      if (k <= 37) begin
        if (o_cs_n !== ((k <= 35) ? 1'b0 : 1'b1)) cs_ok = 1'b0;
        if (o_busy !== ((k <= 36) ? 1'b1 : 1'b0)) busy_ok = 1'b0;
        if (o_done === 1'b1) begin
          done_cnt++;
          if (done_cyc < 0) done_cyc = k;
        end
      end
      if (with5 && done5 === 1'b1 && done5_cyc < 0) done5_cyc = k;
      i_miso = (k >= 24 && k <= 35) ? resp[35-k] : 1'b0;
      miso5  = (k >= 27 && k <= 38) ? resp[38-k] : 1'b0;
      if (!keep && pulse_at > 0) begin
        if (k == pulse_at) i_start = 1'b1;
        else if (k == pulse_at + 1) i_start = 1'b0;
      end
    end
    chk("mosi_stream", 32'(mosi_cap), 32'(v.exp_mosi));
    chk("done_cycle", 32'(done_cyc), 32'd36);
    chk("done_pulse_count", 32'(done_cnt), 32'd1);
    chk("cs_n_pattern", 32'(cs_ok), 32'd1);
    chk("busy_pattern", 32'(busy_ok), 32'd1);
    chk("result", 32'(o_result), 32'(v.rres));
    chk("flags", 32'(o_flags), 32'(v.rflg));
    if (with5) begin
      chk("gap5_done_cycle", 32'(done5_cyc), 32'd39);
      chk("gap5_result", 32'(result5), 32'(v.rres));
      chk("gap5_flags", 32'(flags5), 32'(v.rflg));
    end
    $display("txn a=%02h b=%02h op=%0h mosi=%05h done@%0d result=%02h flags=%0h",
             v.a, v.b, v.op, mosi_cap, done_cyc, o_result, o_flags);
  endtask

  task automatic err_clear();
    @(negedge i_sclk);
    i_err_clr = 1'b1;
    @(negedge i_sclk);
    i_err_clr = 1'b0;
    chk("err_after_clear", 32'(o_err), 32'd0);
  endtask

  initial begin
    vecs[0] = '{a: 8'h12, b: 8'h34, op: 4'h0, rres: 8'h46, rflg: 4'h0, exp_mosi: 20'h12340};
    vecs[1] = '{a: 8'hFF, b: 8'h01, op: 4'h5, rres: 8'h00, rflg: 4'h3, exp_mosi: 20'hFF015};
    vecs[2] = '{a: 8'hA5, b: 8'h3C, op: 4'hA, rres: 8'hC3, rflg: 4'h9, exp_mosi: 20'hA53CA};
    vecs[3] = '{a: 8'h5A, b: 8'hC3, op: 4'h7, rres: 8'h81, rflg: 4'h6, exp_mosi: 20'h5AC37};

    repeat (3) @(negedge i_sclk);
    chk("reset_cs_n", 32'(o_cs_n), 32'd1);
    chk("reset_mosi", 32'(o_mosi), 32'd0);
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_done", 32'(o_done), 32'd0);
    chk("reset_result", 32'(o_result), 32'd0);
    chk("reset_flags", 32'(o_flags), 32'd0);
    chk("reset_err", 32'(o_err), 32'd0);
    i_rst = 1'b1;
    repeat (2) @(negedge i_sclk);

    for (int i = 0; i < 3; i++) run_txn(vecs[i], 1'b0, 0, 1'b1);

    // i_start held through the first frame: the second must start one IDLE cycle after DONE
    run_txn(vecs[3], 1'b1, 0, 1'b0);
    run_txn(vecs[1], 1'b0, 0, 1'b0);
    @(negedge i_sclk);
    chk("err_after_held_start", 32'(o_err), 32'(ERR_EXP));
    err_clear();

    run_txn(vecs[0], 1'b0, 10, 1'b0);
    @(negedge i_sclk);
    chk("idle_after_midframe_start", 32'(o_busy), 32'd0);
    chk("err_after_midframe_start", 32'(o_err), 32'(ERR_EXP));
    err_clear();

    // Reset asserted in cycle 15 of a frame
    i_arg_a = vecs[2].a;
    i_arg_b = vecs[2].b;
    i_oper  = vecs[2].op;
    i_start = 1'b1;
    @(posedge i_sclk);
    #1;
    i_start = 1'b0;
    repeat (14) @(posedge i_sclk);
    #2;
    chk("pre_reset_cs_n", 32'(o_cs_n), 32'd0);
    i_rst = 1'b0;
    #1;
    chk("midreset_cs_n", 32'(o_cs_n), 32'd1);
    chk("midreset_busy", 32'(o_busy), 32'd0);
    chk("midreset_result", 32'(o_result), 32'd0);
    chk("midreset_flags", 32'(o_flags), 32'd0);
    chk("midreset_mosi", 32'(o_mosi), 32'd0);
    @(negedge i_sclk);
    i_rst = 1'b1;
    @(negedge i_sclk);
    run_txn(vecs[3], 1'b0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_exe_host.md
# spi_exe_host

Host-side SPI frame driver that sits directly upstream of the SPI execution unit slave. It accepts one operation (argument A, argument B, opcode) over a parallel start/done handshake, serialises it onto MOSI under chip-select, waits a fixed turnaround, then shifts the result and flag word back in from MISO and presents it in parallel. Everything runs in the serial clock domain, so the slave and this block share the same clock edges.

## Interface
- M, 8, operand/result width in bits
- N, 4, opcode width in bits
- F, 4, flag width in bits (SF, OF, NF, BF in LSB-to-MSB order)
- GAP, 2, turnaround cycles between last opcode bit and first response bit (legal 1..15)
- i_sclk  in  1  serial clock; all logic on posedge
- i_rst  in  1  reset, asynchronous, active-low
- i_start  in  1  request; sampled only in IDLE
- i_arg_a  in  M  operand A, captured on accepted start
- i_arg_b  in  M  operand B, captured on accepted start
- i_oper  in  N  opcode, captured on accepted start
- o_busy  out  1  transaction in progress
- o_done  out  1  one-cycle pulse, response valid
- o_result  out  M  last received result
- o_flags  out  F  last received flags
- o_cs_n  out  1  chip select to slave, active-low
- o_mosi  out  1  serial data to slave
- i_miso  in  1  serial data from slave
- o_err  out  1  sticky protocol error (see Configuration)
- i_err_clr  in  1  clears o_err

## Operation
- States: IDLE, SELECT, SEND, GAP_WAIT, RECV, DONE.
- IDLE: o_cs_n=1, o_mosi=0. i_start=1 -> capture {A,B,oper} into 2M+N-bit TX shift register, go SELECT.
- SELECT: one cycle, o_cs_n=0, o_mosi=0; go SEND.
- SEND: 2M+N cycles; o_mosi = TX MSB, shift left each cycle; order A[M-1]..A[0], B[M-1]..B[0], oper[N-1]..oper[0]. Bit counter reaching last bit -> GAP_WAIT.
- GAP_WAIT: GAP cycles, o_cs_n=0, o_mosi=0; -> RECV.
- RECV: M+F cycles; i_miso sampled every posedge into RX register MSB-first: result[M-1]..result[0], flags[F-1]..flags[0]. Last bit -> DONE.
- DONE: one cycle; o_cs_n=1, o_done=1, o_result/o_flags loaded from RX; -> IDLE.
- o_busy=1 in every state except IDLE.
- i_start outside IDLE ignored (no queueing); TX/RX contents unaffected.
- o_result/o_flags hold value until next DONE.
- All outputs registered; no combinational path from inputs to outputs.

## Timing
- Reset (async assert, sync release): state IDLE, o_cs_n=1, o_mosi=0, o_busy=0, o_done=0, o_result=0, o_flags=0, o_err=0, counters and shift registers 0.
- Start accepted at edge 0 -> SELECT in cycle 1, first MOSI bit cycle 2, last MOSI bit cycle 2M+N+1, GAP cycles, RECV cycles 2M+N+GAP+2 .. 3M+N+F+GAP+1, o_done cycle 3M+N+F+GAP+2 (36 at defaults).
- i_start high during DONE cycle: ignored; earliest next acceptance is the first IDLE cycle, giving back-to-back gap of one IDLE cycle with o_cs_n=1 (re-arms the slave).
- Reset mid-transaction: immediate return to IDLE values, o_cs_n=1, partial RX discarded, o_result/o_flags cleared.
- Bit counter width $clog2(2M+N+1); GAP counter 4 bits; no wrap beyond terminal count.

## Configuration
- SPI_EXE_HOST_ERR_EN defined: o_err sets (sticky) when i_start=1 while o_busy=1; cleared by i_err_clr=1 in a cycle with no new violation (set wins on simultaneous events).
- Not defined: o_err tied 0, i_err_clr ignored, no error register synthesised. Start-while-busy still ignored.

## Structure
- Shared package spi_exe_pkg: state enum, default M/N/F constants, frame length constants TX_BITS=2M+N, RX_BITS=M+F.
- One sub-module: spi_exe_host_shreg, parameterised-width shift register with parallel load, serial in/out, shift enable; instanced for TX (parallel load, serial out) and RX (serial in, parallel out).

## Test plan
- A=0x12, B=0x34, oper=0x0, miso model returns 0x46 then flags 0x0 -> MOSI stream 0x12,0x34,0x0 MSB-first, o_done at cycle 36, o_result=0x46, o_flags=0x0.
- A=0xFF, B=0x01, miso returns result 0x00 flags 0b0011 -> o_result=0x00, o_flags=0x3, o_cs_n high exactly in DONE cycle.
- i_start held continuously -> transactions separated by exactly one o_cs_n=1 IDLE cycle plus DONE; each captures current args.
- i_start pulsed in cycle 10 of a transaction -> ignored, o_result unchanged; with SPI_EXE_HOST_ERR_EN o_err=1 until i_err_clr, without it o_err=0.
- i_rst low in cycle 15 -> o_cs_n=1, o_busy=0, o_result=0 same cycle; fresh start after release completes normally.
- GAP=5 build -> o_done at cycle 39, first miso sample cycle 27.
